// File: rtl/cache_pkg.sv
// Shared definitions for the cache miss/fill path: FSM encodings, requester ids and line geometry.
package cache_pkg;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WB   = 2'd1;
   localparam logic [1:0] FILL = 2'd2;
   localparam logic [1:0] RESP = 2'd3;

   localparam logic IC = 1'b0;
   localparam logic DC = 1'b1;

   localparam int LINE_OFFSET_W = 4;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant between the iCache and dCache miss requests.
module rr_arbiter2
   import cache_pkg::*;
(
   input  logic ic_req,
   input  logic dc_req,
   input  logic last_grant,
   output logic grant_valid,
   output logic grant_id
);

   assign grant_valid = ic_req | dc_req;

   // On a tie the requester that was not served last wins.
   always_comb begin
      grant_id = IC;
      if (ic_req && dc_req) begin
         grant_id = ~last_grant;
      end else if (dc_req) begin
         grant_id = DC;
      end
   end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one line-wide memory port between iCache and dCache misses, sequencing an optional
// dirty-line writeback followed by a fixed-latency line fill.
module cache_mem_arbiter
   import cache_pkg::*;
#(
   parameter int ADDR_WIDTH  = 32,
   parameter int BITS_LINE   = 128,
   parameter int MEM_LATENCY = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ic_req,
   input  logic [ADDR_WIDTH-1:0] ic_addr,
   output logic                  ic_done,
   output logic [BITS_LINE-1:0]  ic_fill_data,
   input  logic                  dc_req,
   input  logic [ADDR_WIDTH-1:0] dc_addr,
   input  logic                  dc_wb,
   input  logic [ADDR_WIDTH-1:0] dc_wb_addr,
   input  logic [BITS_LINE-1:0]  dc_wb_data,
   output logic                  dc_done,
   output logic [BITS_LINE-1:0]  dc_fill_data,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [BITS_LINE-1:0]  mem_wdata,
   input  logic [BITS_LINE-1:0]  mem_rdata
);

   localparam int                    CNT_W     = $clog2(MEM_LATENCY + 1);
   localparam logic [CNT_W-1:0]      CNT_LOAD  = CNT_W'(MEM_LATENCY - 1);
   localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'((1 << LINE_OFFSET_W) - 1);

   logic [1:0]            state;
   logic [CNT_W-1:0]      cnt;
   logic                  last_grant;
   logic                  owner;
   logic [ADDR_WIDTH-1:0] fill_line;
   logic                  grant_valid;
   logic                  grant_id;
   logic [ADDR_WIDTH-1:0] req_line;
   logic [ADDR_WIDTH-1:0] wb_line;
   logic                  start_wb;

   rr_arbiter2 u_arb (
      .ic_req      (ic_req),
      .dc_req      (dc_req),
      .last_grant  (last_grant),
      .grant_valid (grant_valid),
      .grant_id    (grant_id)
   );

   // Line-aligned addresses of the candidate grant; dc_wb only matters when the dCache wins.
   always_comb begin
      req_line = ((grant_id == DC) ? dc_addr : ic_addr) & LINE_MASK;
      wb_line  = dc_wb_addr & LINE_MASK;
      start_wb = (grant_id == DC) && dc_wb;
   end

   // Every access runs cnt from MEM_LATENCY-1 down to 0, so mem_req stays high MEM_LATENCY cycles.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         cnt          <= '0;
         last_grant   <= IC;
         owner        <= IC;
         fill_line    <= '0;
         ic_done      <= 1'b0;
         dc_done      <= 1'b0;
         ic_fill_data <= '0;
         dc_fill_data <= '0;
         mem_req      <= 1'b0;
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
      end else begin
         ic_done <= 1'b0;
         dc_done <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_valid) begin
                  owner      <= grant_id;
                  last_grant <= grant_id;
                  fill_line  <= req_line;
                  cnt        <= CNT_LOAD;
                  mem_req    <= 1'b1;
                  if (start_wb) begin
                     state     <= WB;
                     mem_we    <= 1'b1;
                     mem_addr  <= wb_line;
                     mem_wdata <= dc_wb_data;
                  end else begin
                     state    <= FILL;
                     mem_we   <= 1'b0;
                     mem_addr <= req_line;
                  end
               end
            end
            WB: begin
               if (cnt == '0) begin
                  state    <= FILL;
                  cnt      <= CNT_LOAD;
                  mem_we   <= 1'b0;
                  mem_addr <= fill_line;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            FILL: begin
               if (cnt == '0) begin
                  state   <= RESP;
                  mem_req <= 1'b0;
                  if (owner == DC) begin
                     dc_fill_data <= mem_rdata;
                     dc_done      <= 1'b1;
                  end else begin
                     ic_fill_data <= mem_rdata;
                     ic_done      <= 1'b1;
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Scoreboard bench for cache_mem_arbiter: directed misses against a 4-cycle and a 1-cycle memory.
`timescale 1ns/1ps
module tb_cache_mem_arbiter;

   localparam int AW = 32;
   localparam int BL = 128;

   typedef struct {
      logic          is_dc;
      logic [BL-1:0] data;
      int            due;
   } done_t;

   typedef struct {
      logic          we;
      logic [AW-1:0] addr;
      logic [BL-1:0] wdata;
      int            len;
   } seg_t;

   logic          clk = 1'b0;
   logic          reset;
   logic          ic_req, dc_req, dc_wb;
   logic [AW-1:0] ic_addr, dc_addr, dc_wb_addr;
   logic [BL-1:0] dc_wb_data, mem_rdata;
   logic          ic_done, dc_done, mem_req, mem_we;
   logic [BL-1:0] ic_fill_data, dc_fill_data, mem_wdata;
   logic [AW-1:0] mem_addr;

   logic          f_dc_req, f_dc_wb;
   logic [AW-1:0] f_dc_addr, f_dc_wb_addr;
   logic [BL-1:0] f_dc_wb_data, f_mem_rdata;
   logic          f_ic_done, f_dc_done, f_mem_req, f_mem_we;
   logic [BL-1:0] f_ic_fill_data, f_dc_fill_data, f_mem_wdata;
   logic [AW-1:0] f_mem_addr;

   int    n_cmp = 0;
   int    n_bad = 0;
   int    cyc   = 0;
   done_t exp_done[$];
   done_t f_exp_done[$];
   seg_t  exp_seg[$];
   seg_t  cur;
   bit    seg_on = 1'b0;

   cache_mem_arbiter #(.ADDR_WIDTH(AW), .BITS_LINE(BL), .MEM_LATENCY(4)) dut (
      .clk(clk), .reset(reset),
      .ic_req(ic_req), .ic_addr(ic_addr), .ic_done(ic_done), .ic_fill_data(ic_fill_data),
      .dc_req(dc_req), .dc_addr(dc_addr), .dc_wb(dc_wb), .dc_wb_addr(dc_wb_addr),
      .dc_wb_data(dc_wb_data), .dc_done(dc_done), .dc_fill_data(dc_fill_data),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   cache_mem_arbiter #(.ADDR_WIDTH(AW), .BITS_LINE(BL), .MEM_LATENCY(1)) dut_fast (
      .clk(clk), .reset(reset),
      .ic_req(1'b0), .ic_addr('0), .ic_done(f_ic_done), .ic_fill_data(f_ic_fill_data),
      .dc_req(f_dc_req), .dc_addr(f_dc_addr), .dc_wb(f_dc_wb), .dc_wb_addr(f_dc_wb_addr),
      .dc_wb_data(f_dc_wb_data), .dc_done(f_dc_done), .dc_fill_data(f_dc_fill_data),
      .mem_req(f_mem_req), .mem_we(f_mem_we), .mem_addr(f_mem_addr), .mem_wdata(f_mem_wdata),
      .mem_rdata(f_mem_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_output(input string name, input logic [BL-1:0] got, input logic [BL-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   function automatic logic [AW-1:0] line_of(input logic [AW-1:0] a);
      return {a[AW-1:4], 4'h0};
   endfunction

   // Done pulses of the 4-cycle instance are matched in order against the expected queue.
   always @(negedge clk) begin : mon_done
      done_t d;
      if (ic_done || dc_done) begin
         check_output("done_exclusive", BL'(ic_done & dc_done), '0);
         if (exp_done.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("[TB] FAIL unexpected_done: got ic=%0b dc=%0b expected no pulse", ic_done, dc_done);
         end else begin
            d = exp_done.pop_front();
            check_output("done_port", BL'(dc_done), BL'(d.is_dc));
            check_output("fill_data", dc_done ? dc_fill_data : ic_fill_data, d.data);
            check_output("done_cycle", BL'(cyc), BL'(d.due));
         end
      end
   end

   // Memory accesses are collapsed into segments of constant we/addr and checked on close.
   always @(negedge clk) begin : mon_mem
      seg_t s;
      if (seg_on && (!mem_req || mem_we !== cur.we || mem_addr !== cur.addr)) begin
         seg_on = 1'b0;
         if (exp_seg.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("[TB] FAIL unexpected_access: got we=%0b addr=%h expected none", cur.we, cur.addr);
         end else begin
            s = exp_seg.pop_front();
            check_output("access_we", BL'(cur.we), BL'(s.we));
            check_output("access_addr", BL'(cur.addr), BL'(s.addr));
            check_output("access_len", BL'(cur.len), BL'(s.len));
            if (s.we) check_output("access_wdata", cur.wdata, s.wdata);
         end
      end
      if (mem_req && !seg_on) begin
         seg_on    = 1'b1;
         cur.we    = mem_we;
         cur.addr  = mem_addr;
         cur.wdata = mem_wdata;
         cur.len   = 0;
      end
      if (seg_on) cur.len++;
   end

   always @(negedge clk) begin : mon_fast
      done_t d;
      if (f_ic_done) check_output("fast_ic_done", BL'(f_ic_done), '0);
      if (f_dc_done) begin
         if (f_exp_done.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("[TB] FAIL fast_unexpected_done: got dc_done=1 expected no pulse");
         end else begin
            d = f_exp_done.pop_front();
            check_output("fast_fill_data", f_dc_fill_data, d.data);
            check_output("fast_done_cycle", BL'(cyc), BL'(d.due));
         end
      end
   end

   task automatic wait_done(input logic is_dc);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (is_dc ? dc_done : ic_done) seen = 1'b1;
      end
      if (is_dc) dc_req = 1'b0;
      else ic_req = 1'b0;
      check_output("done_within_budget", BL'(seen), BL'(1'b1));
   endtask

   task automatic apply_stimulus(input logic is_dc, input logic [AW-1:0] addr, input logic wb,
                                 input logic [AW-1:0] wb_addr, input logic [BL-1:0] wb_data,
                                 input logic [BL-1:0] rdata);
      seg_t  s;
      done_t d;
      int    e;
      @(negedge clk);
      e = cyc + 1;
      mem_rdata = rdata;
      if (is_dc && wb) begin
         s.we = 1'b1; s.addr = line_of(wb_addr); s.wdata = wb_data; s.len = 4;
         exp_seg.push_back(s);
      end
      s.we = 1'b0; s.addr = line_of(addr); s.wdata = '0; s.len = 4;
      exp_seg.push_back(s);
      d.is_dc = is_dc; d.data = rdata; d.due = e + ((is_dc && wb) ? 8 : 4);
      exp_done.push_back(d);
      dc_wb = wb; dc_wb_addr = wb_addr; dc_wb_data = wb_data;
      if (is_dc) begin
         dc_addr = addr; dc_req = 1'b1;
      end else begin
         ic_addr = addr; ic_req = 1'b1;
      end
      wait_done(is_dc);
   endtask

   // Both caches miss in the same cycle; the second grant samples two edges after the first done.
   task automatic apply_pair(input logic dc_first, input logic [AW-1:0] i_addr,
                             input logic [AW-1:0] d_addr, input logic [BL-1:0] rdata);
      seg_t  s;
      done_t d;
      int    e;
      logic  serve_dc;
      @(negedge clk);
      e = cyc + 1;
      mem_rdata = rdata;
      for (int k = 0; k < 2; k++) begin
         serve_dc = (k == 0) ? dc_first : !dc_first;
         s.we = 1'b0; s.addr = serve_dc ? line_of(d_addr) : line_of(i_addr); s.wdata = '0; s.len = 4;
         exp_seg.push_back(s);
         d.is_dc = serve_dc; d.data = rdata; d.due = e + 4 + k * 6;
         exp_done.push_back(d);
      end
      ic_addr = i_addr; dc_addr = d_addr; dc_wb = 1'b0;
      ic_req = 1'b1; dc_req = 1'b1;
      for (int i = 0; i < 60 && (ic_req || dc_req); i++) begin
         @(negedge clk);
         if (ic_done) ic_req = 1'b0;
         if (dc_done) dc_req = 1'b0;
      end
      check_output("pair_within_budget", BL'({ic_req, dc_req}), '0);
      ic_req = 1'b0; dc_req = 1'b0;
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      seg_t  s;
      done_t d;
      int    e;
      reset = 1'b1;
      ic_req = 1'b0; dc_req = 1'b0; dc_wb = 1'b0;
      ic_addr = '0; dc_addr = '0; dc_wb_addr = '0; dc_wb_data = '0; mem_rdata = '0;
      f_dc_req = 1'b0; f_dc_wb = 1'b0; f_dc_addr = '0; f_dc_wb_addr = '0;
      f_dc_wb_data = '0; f_mem_rdata = '0;
      repeat (3) @(negedge clk);
      check_output("rst_mem_req", BL'(mem_req), '0);
      check_output("rst_mem_we", BL'(mem_we), '0);
      check_output("rst_mem_addr", BL'(mem_addr), '0);
      check_output("rst_mem_wdata", mem_wdata, '0);
      check_output("rst_done", BL'({ic_done, dc_done}), '0);
      check_output("rst_ic_fill", ic_fill_data, '0);
      check_output("rst_dc_fill", dc_fill_data, '0);
      reset = 1'b0;
      @(negedge clk);
      check_output("idle_mem_req", BL'(mem_req), '0);

      // iCache-only fill; dc_wb is driven high but must be ignored without dc_req.
      apply_stimulus(1'b0, 32'h0000_1234, 1'b1, 32'h0000_0777, {4{32'hFFFF_FFFF}}, {16{8'hAA}});

      // dCache writeback of a dirty victim followed by its fill.
      apply_stimulus(1'b1, 32'h0000_0080, 1'b1, 32'h0000_0040,
                     128'h5544_3322_1100_9988_7766_5544_3322_1100,
                     128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210);
      @(negedge clk);
      check_output("ic_fill_hold", ic_fill_data, {16{8'hAA}});
      check_output("dc_fill_hold", dc_fill_data, 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210);

      // Simultaneous misses after reset go dCache first, then alternate.
      pulse_reset();
      apply_pair(1'b1, 32'h0000_0204, 32'h0000_0308, {4{32'hC0DE_0001}});
      apply_stimulus(1'b1, 32'h0000_0410, 1'b0, 32'h0, '0, {4{32'hC0DE_0002}});
      apply_pair(1'b0, 32'h0000_0520, 32'h0000_063c, {4{32'hC0DE_0003}});

      // Reset in the middle of a fill with cnt at 2: no done pulse, partial access of 2 cycles.
      @(negedge clk);
      mem_rdata = {4{32'h1111_2222}};
      ic_addr = 32'h0000_0560;
      ic_req = 1'b1;
      s.we = 1'b0; s.addr = 32'h0000_0560; s.wdata = '0; s.len = 2;
      exp_seg.push_back(s);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      #2;
      reset = 1'b1;
      ic_req = 1'b0;
      #1;
      check_output("abort_mem_req", BL'(mem_req), '0);
      check_output("abort_mem_addr", BL'(mem_addr), '0);
      @(negedge clk);
      reset = 1'b0;
      repeat (6) @(negedge clk);
      check_output("abort_no_fill", ic_fill_data, '0);
      apply_stimulus(1'b0, 32'h0000_0ff8, 1'b0, 32'h0, '0, {4{32'h7E57_0001}});

      // One-cycle memory: fill only, request dropped right after being sampled.
      @(negedge clk);
      f_dc_addr = 32'h0000_0abc; f_dc_wb = 1'b0; f_mem_rdata = {4{32'hBAD0_BAD0}};
      e = cyc + 1;
      d.is_dc = 1'b1; d.data = {4{32'h600D_0001}}; d.due = e + 1;
      f_exp_done.push_back(d);
      f_dc_req = 1'b1;
      @(negedge clk);
      check_output("fast_fill_req", BL'(f_mem_req), BL'(1'b1));
      check_output("fast_fill_we", BL'(f_mem_we), '0);
      check_output("fast_fill_addr", BL'(f_mem_addr), BL'(32'h0000_0ab0));
      f_dc_req = 1'b0;
      f_mem_rdata = {4{32'h600D_0001}};
      @(negedge clk);
      f_mem_rdata = {4{32'hBAD1_BAD1}};
      check_output("fast_req_low", BL'(f_mem_req), '0);

      // One-cycle memory with writeback: one WB cycle then one FILL cycle.
      @(negedge clk);
      @(negedge clk);
      f_dc_addr = 32'h0000_0cc4; f_dc_wb = 1'b1; f_dc_wb_addr = 32'h0000_0d08;
      f_dc_wb_data = {4{32'hD1D1_0002}};
      e = cyc + 1;
      d.is_dc = 1'b1; d.data = {4{32'h600D_0002}}; d.due = e + 2;
      f_exp_done.push_back(d);
      f_dc_req = 1'b1;
      @(negedge clk);
      check_output("fast_wb_we", BL'(f_mem_we), BL'(1'b1));
      check_output("fast_wb_addr", BL'(f_mem_addr), BL'(32'h0000_0d00));
      check_output("fast_wb_data", f_mem_wdata, {4{32'hD1D1_0002}});
      @(negedge clk);
      check_output("fast_wbfill_req", BL'(f_mem_req), BL'(1'b1));
      check_output("fast_wbfill_we", BL'(f_mem_we), '0);
      check_output("fast_wbfill_addr", BL'(f_mem_addr), BL'(32'h0000_0cc0));
      f_mem_rdata = {4{32'h600D_0002}};
      @(negedge clk);
      f_dc_req = 1'b0;
      f_mem_rdata = {4{32'hBAD2_BAD2}};

      repeat (4) @(negedge clk);
      check_output("done_queue_empty", BL'(exp_done.size()), '0);
      check_output("access_queue_empty", BL'(exp_seg.size()), '0);
      check_output("fast_queue_empty", BL'(f_exp_done.size()), '0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
